int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller on the CPU bus: the receiving end for the single-cycle interrupt pulses produced by the bus timer/counter and other peripherals. It latches up to N_SRC request lines into a pending register, masks them, and selects the lowest-numbered enabled pending source. It presents that source to the CPU through a request/acknowledge/done handshake. Software reaches the mask, pending and control registers through a simple word-addressed register port.

## Interface
- N_SRC, 8, number of interrupt sources (1..32)
- ID_W, 3, width of source ID; must equal clog2(N_SRC), minimum 1
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- src  input  N_SRC  interrupt request lines from peripherals (e.g. counter int)
- we  input  1  register write strobe
- addr  input  2  register word address
- wdata  input  32  register write data
- rdata  output  32  register read data, combinational from addr
- irq_req  output  1  interrupt request to CPU
- irq_id  output  ID_W  ID of requested/in-service source
- irq_ack  input  1  CPU accepts request (one-cycle pulse)
- irq_done  input  1  CPU finished handler (mret), one-cycle pulse

## Operation
- Registers:
  - addr 0 EN (RW, N_SRC bits): per-source enable.
  - addr 1 PEND (R; write 1 to clear).
  - addr 2 CTRL (RW, bit0 GIE global enable).
  - addr 3 STAT (RO): bits[1:0] state, bits[8+ID_W-1:8] irq_id.
  - Unused bits read 0.
- Reset values: EN=0, PEND=0, GIE=0, src_q=0, state=IDLE, irq_req=0, irq_id=0, rdata follows addr (0 for EN/PEND/CTRL).
- Source capture: src_q registers src each cycle. Event = src & ~src_q (see Configuration). An event sets PEND[i].
- PEND set and W1C clear of the same bit in the same cycle: set wins, so no event is lost. Disabled sources still accumulate pending bits.
- Eligible = PEND & EN, gated by GIE. Winner = lowest index set.
- FSM:
  - IDLE: if any eligible, go to REQ and latch irq_id = winner.
  - REQ: irq_req=1 and irq_id is held. There is no preemption, so a higher-priority arrival does not change irq_id.
    - irq_ack=1: clear PEND[irq_id] and go to SERVE.
    - irq_ack=0 with PEND[irq_id]&EN[irq_id]&GIE = 0 (software withdrew the request): drop irq_req and go to IDLE.
    - Ack takes precedence over withdrawal in the same cycle.
  - SERVE: irq_req=0 and irq_id is held. irq_done=1 moves to IDLE. New events keep pending.
- irq_ack outside REQ is ignored. irq_done outside SERVE is ignored.
- A new event on the in-service source during REQ/SERVE re-sets its PEND bit (including in the ack cycle, since set wins). That source is requested again after done.
- State encoding: IDLE=0, REQ=1, SERVE=2.

## Timing
- src rising in cycle t → PEND visible in cycle t+1 → state REQ and irq_req=1 in cycle t+2 (2-cycle latency).
- irq_ack at cycle a → PEND bit clear and irq_req=0 from cycle a+1.
- irq_done at cycle d → IDLE at d+1. The earliest next irq_req is d+2.
- Register writes take effect on the next edge. rdata reflects the current register values with no wait states.
- Asynchronous reset mid-handshake: immediate return to IDLE. All pending bits are lost and irq_req deasserts without waiting for a clock.

## Configuration
- INTC_EDGE_EN defined: event = rising edge of src (src & ~src_q). A held-high line produces one pending set.
- INTC_EDGE_EN undefined: level mode, event = src. PEND[i] re-sets every cycle the line is high, so W1C has no lasting effect while the line is asserted. src_q is not implemented.
- Reset values and handshake are identical in both modes.

## Test plan
- Reset, EN=0xFF, GIE=1, pulse src[3] for 1 cycle at t → PEND=0x08 at t+1, irq_req=1 with irq_id=3 at t+2. Ack → PEND=0, SERVE. Done → IDLE.
- With EN=0xFF and GIE=1, pulse src[5] and src[2] in the same cycle → irq_id=2 first. After ack+done, irq_id=5 is requested 2 cycles after the done pulse.
- In REQ with irq_id=4, pulse src[1] → irq_id stays 4. After done, src 1 is served.
- In REQ with irq_id=0, write EN=0 with irq_ack low → irq_req drops and state becomes IDLE next cycle. PEND[0] remains 1.
- Write PEND=0x01 (W1C) in the same cycle as a src[0] event → PEND[0] remains 1.
- Assert rst_n=0 asynchronously while in SERVE → irq_req=0, STAT=0, PEND=0, and EN=0 immediately. Edge build: a src[0] held high for 10 cycles gives exactly one request. Level build: the request repeats after each done.

Source files
------------

// File: rtl/int_ctrl.sv
// int_ctrl: masked, fixed-priority (lowest index wins) interrupt controller with a req/ack/done CPU handshake.
// Build option INTC_EDGE_EN: rising-edge capture of src; when undefined, src is captured as a level.
module int_ctrl #(
   parameter int unsigned N_SRC = 8,
   parameter int unsigned ID_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_SRC-1:0] src,
   input  logic             we,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic             irq_req,
   output logic [ID_W-1:0]  irq_id,
   input  logic             irq_ack,
   input  logic             irq_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      SERVE = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [N_SRC-1:0] en_q, en_d;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic             gie_q, gie_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [N_SRC-1:0] evt;
   logic [N_SRC-1:0] elig;
   logic [ID_W-1:0]  win;
   logic             any_elig;
   logic             cur_elig;
   logic             unused_wdata;

   assign unused_wdata = ^wdata;

`ifdef INTC_EDGE_EN
   logic [N_SRC-1:0] src_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) src_q <= '0;
      else        src_q <= src;
   end

   assign evt = src & ~src_q;
`else
   assign evt = src;
`endif

   assign elig     = pend_q & en_q & {N_SRC{gie_q}};
   assign any_elig = |elig;
   assign cur_elig = pend_q[id_q] & en_q[id_q] & gie_q;

   // Scan downward so the lowest set index is the last assignment.
   always_comb begin
      win = '0;
      for (int unsigned i = N_SRC; i > 0; i--) begin
         if (elig[i-1]) win = ID_W'(i - 1);
      end
   end

   always_comb begin
      en_d    = en_q;
      gie_d   = gie_q;
      pend_d  = pend_q;
      state_d = state_q;
      id_d    = id_q;
      irq_req = 1'b0;

      if (we) begin
         case (addr)
            2'd0:    en_d   = wdata[N_SRC-1:0];
            2'd1:    pend_d = pend_q & ~wdata[N_SRC-1:0];
            2'd2:    gie_d  = wdata[0];
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (any_elig) begin
               state_d = REQ;
               id_d    = win;
            end
         end
         REQ: begin
            irq_req = 1'b1;
            if (irq_ack) begin
               pend_d[id_q] = 1'b0;
               state_d      = SERVE;
            end else if (!cur_elig) begin
               state_d = IDLE;
            end
         end
         SERVE: begin
            if (irq_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // New events are merged last so a same-cycle clear never loses one.
      pend_d = pend_d | evt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         en_q    <= '0;
         pend_q  <= '0;
         gie_q   <= 1'b0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         en_q    <= en_d;
         pend_q  <= pend_d;
         gie_q   <= gie_d;
         id_q    <= id_d;
      end
   end

   assign irq_id = id_q;

   always_comb begin
      rdata = '0;
      case (addr)
         2'd0: rdata[N_SRC-1:0] = en_q;
         2'd1: rdata[N_SRC-1:0] = pend_q;
         2'd2: rdata[0]         = gie_q;
         2'd3: begin
            rdata[1:0]       = state_q;
            rdata[8 +: ID_W] = id_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; expectations are hand-derived constants.
module tb_int_ctrl;

   logic        clk;
   logic        rst_n;
   logic [7:0]  src;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq_req;
   logic [2:0]  irq_id;
   logic        irq_ack;
   logic        irq_done;

   int n_checks = 0;
   int n_errors = 0;
   int n_acks;

   int_ctrl #(.N_SRC(8), .ID_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .src      (src),
      .we       (we),
      .addr     (addr),
      .wdata    (wdata),
      .rdata    (rdata),
      .irq_req  (irq_req),
      .irq_id   (irq_id),
      .irq_ack  (irq_ack),
      .irq_done (irq_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      tick();
      we    = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      check(tag, rdata, exp);
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic pulse_done();
      irq_done = 1'b1;
      tick();
      irq_done = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; src = '0; we = 1'b0; addr = '0; wdata = '0;
      irq_ack = 1'b0; irq_done = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      check("rst_req", irq_req, 0);
      check("rst_id", irq_id, 0);
      rd_chk("rst_en", 2'd0, 0);
      rd_chk("rst_pend", 2'd1, 0);
      rd_chk("rst_ctrl", 2'd2, 0);
      rd_chk("rst_stat", 2'd3, 0);

      wr(2'd0, 32'hFF);
      wr(2'd2, 32'h1);
      rd_chk("en_rb", 2'd0, 32'hFF);
      rd_chk("ctrl_rb", 2'd2, 32'h1);

      // Single source, 2-cycle latency
      src = 8'h08; tick(); src = '0;
      rd_chk("t1_pend", 2'd1, 32'h08);
      check("t1_req_early", irq_req, 0);
      tick();
      check("t1_req", irq_req, 1);
      check("t1_id", irq_id, 3);
      rd_chk("t1_stat_req", 2'd3, 32'h301);
      pulse_ack();
      check("t1_req_ack", irq_req, 0);
      rd_chk("t1_pend_ack", 2'd1, 0);
      rd_chk("t1_stat_serve", 2'd3, 32'h302);
      pulse_done();
      rd_chk("t1_stat_idle", 2'd3, 32'h300);

      // Two simultaneous sources: lowest index first
      src = 8'h24; tick(); src = '0;
      tick();
      check("t2_id_first", irq_id, 2);
      check("t2_req_first", irq_req, 1);
      pulse_ack();
      rd_chk("t2_pend_left", 2'd1, 32'h20);
      pulse_done();
      check("t2_req_d1", irq_req, 0);
      tick();
      check("t2_req_d2", irq_req, 1);
      check("t2_id_second", irq_id, 5);
      pulse_ack();
      pulse_done();

      // No preemption while requesting
      src = 8'h10; tick(); src = '0;
      tick();
      check("t3_id4", irq_id, 4);
      src = 8'h02; tick(); src = '0;
      check("t3_id_hold1", irq_id, 4);
      tick();
      check("t3_id_hold2", irq_id, 4);
      check("t3_req_hold", irq_req, 1);
      pulse_ack();
      rd_chk("t3_stat_serve", 2'd3, 32'h402);
      rd_chk("t3_pend", 2'd1, 32'h02);
      pulse_done();
      tick();
      check("t3_id1", irq_id, 1);
      check("t3_req1", irq_req, 1);
      pulse_ack();
      pulse_done();

      // Software withdrawal by clearing EN
      src = 8'h01; tick(); src = '0;
      tick();
      check("t4_req", irq_req, 1);
      check("t4_id0", irq_id, 0);
      wr(2'd0, 32'h0);
      tick();
      check("t4_req_drop", irq_req, 0);
      rd_chk("t4_stat_idle", 2'd3, 32'h000);
      rd_chk("t4_pend_kept", 2'd1, 32'h01);
      wr(2'd1, 32'h01);
      rd_chk("t4_w1c", 2'd1, 0);
      wr(2'd0, 32'hFF);

      // Stray ack/done in IDLE are ignored
      irq_ack = 1'b1; irq_done = 1'b1; tick(); irq_ack = 1'b0; irq_done = 1'b0;
      rd_chk("t5_stray", 2'd3, 32'h000);

      // W1C and new event on the same bit: set wins
      src = 8'h01;
      wr(2'd1, 32'h01);
      src = '0;
      rd_chk("t6_set_wins", 2'd1, 32'h01);
      tick();
      check("t6_req", irq_req, 1);
      check("t6_id", irq_id, 0);
      pulse_ack();
      pulse_done();

      // GIE gating
      wr(2'd2, 32'h0);
      src = 8'h40; tick(); src = '0;
      tick(); tick();
      check("t7_gie_off", irq_req, 0);
      rd_chk("t7_pend", 2'd1, 32'h40);
      wr(2'd2, 32'h1);
      tick();
      check("t7_req", irq_req, 1);
      check("t7_id6", irq_id, 6);
      pulse_ack();
      pulse_done();

      // Asynchronous reset while in SERVE, with another source pending
      src = 8'h01; tick(); src = '0;
      tick();
      pulse_ack();
      src = 8'h80; tick(); src = '0;
      rd_chk("t8_serve", 2'd3, 32'h002);
      rst_n = 1'b0;
      #1;
      check("t8_rst_req", irq_req, 0);
      rd_chk("t8_rst_stat", 2'd3, 0);
      rd_chk("t8_rst_pend", 2'd1, 0);
      rd_chk("t8_rst_en", 2'd0, 0);
      tick();
      rst_n = 1'b1;
      wr(2'd0, 32'hFF);
      wr(2'd2, 32'h1);

      // src[0] held high for 10 cycles with an auto-responding CPU
      addr = 2'd3;
      n_acks = 0;
      src = 8'h01;
      #1;
      for (int i = 0; i < 16; i++) begin
         if (i == 10) src = '0;
         irq_ack  = (rdata[1:0] == 2'd1);
         irq_done = (rdata[1:0] == 2'd2);
         if (irq_ack) n_acks++;
         tick();
      end
      irq_ack = 1'b0; irq_done = 1'b0;
`ifdef INTC_EDGE_EN
      check("t9_req_count", n_acks, 1);
`else
      check("t9_req_count", n_acks, 4);
`endif
      rd_chk("t9_pend_end", 2'd1, 0);
      rd_chk("t9_stat_end", 2'd3, 32'h000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
